instruction_register: RTL and testbench
=======================================

# instruction_register

Parametrised JTAG instruction register that replaces the per-bit instruction cell with one WIDTH-bit unit. It sits between the TAP controller and the instruction decoder, with a shift stage and an update (shadow) stage. Everything runs on a single clock, gated by capture/shift/update enables. It adds three behaviours the per-bit cell lacked: an IEEE 1149.1 capture pattern, a shift-length check, and a defined reset instruction.

## Interface
- WIDTH, 4, instruction length in bits; minimum 3.
- RESET_INSTR, all ones (BYPASS), value loaded into Q by Reset.
- ClockIR  input  1  clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- TDI  input  1  serial data in; enters the shift register at bit WIDTH-1.
- CaptureIR  input  1  capture enable from the TAP controller.
- ShiftIR  input  1  shift enable.
- UpdateIR  input  1  update enable; transfers the shift register to Q.
- Status  input  WIDTH-2  status bits captured into shift[WIDTH-1:2].
- TDO  output  1  serial data out; equals shift[0] (flop output, no combinational path from TDI).
- Q  output  WIDTH  current instruction presented to the decoder.
- LengthErr  output  1  set when an update follows a shift count other than WIDTH.

## Operation
- State:
  - shift[WIDTH-1:0]
  - Q[WIDTH-1:0]
  - cnt, $clog2(WIDTH+2) bits, saturating at WIDTH+1
  - LengthErr
- Reset (highest priority), at the clock edge:
  - shift = 0, TDO = 0
  - Q = RESET_INSTR
  - cnt = 0, LengthErr = 0
  - All enables are ignored in that cycle.
- Shift-register priority: CaptureIR > ShiftIR > hold.
- Capture:
  - shift[1:0] = 2'b01.
  - shift[WIDTH-1:2] = Status (macro enabled) or 0 (macro disabled).
  - cnt = 0; LengthErr cleared.
- Shift:
  - shift = {TDI, shift[WIDTH-1:1]}, LSB first out on TDO.
  - cnt increments, saturating at WIDTH+1.
- Update is evaluated independently of capture/shift:
  - Q = the shift value held before this edge.
  - LengthErr is set if cnt != WIDTH; otherwise it is unchanged.
  - Q is loaded even when the length is wrong; the flag is advisory.
- Simultaneous events:
  - Update together with shift or capture: Q takes the pre-edge shift value, and the shift register performs its own operation.
  - The length check uses the pre-edge cnt.
- LengthErr is sticky until the next capture or Reset.

## Timing
- Capture to TDO: the captured bit 1 appears on TDO one edge after CaptureIR.
- Shift: TDO changes on each ShiftIR edge; TDI sampled at edge k reaches TDO after WIDTH shift edges.
- Update: Q is valid at the same edge UpdateIR is sampled, so decoder latency is 1 cycle.
- LengthErr is valid at the same edge as the update.
- Reset mid-shift aborts the scan: Q reverts to RESET_INSTR on that edge, and partial shift data is discarded.
- Enables held high for multiple cycles act once per cycle (no edge detection). For example, UpdateIR high for 2 cycles reloads Q twice with the held shift value.

## Configuration
- IR_CAPTURE_STATUS_EN defined:
  - Capture loads Status into shift[WIDTH-1:2].
- IR_CAPTURE_STATUS_EN undefined:
  - Capture loads zeros into shift[WIDTH-1:2].
  - The Status port remains but is unused.
  - Capture value is exactly {(WIDTH-2){0}, 2'b01}.

## Test plan
- Reset with WIDTH=4, then release -> Q=4'b1111, TDO=0, LengthErr=0.
- Capture with Status=2'b10 (macro on) then 4 shifts with TDI=1,0,1,0 -> TDO sequence 1,0,0,1; then Update -> Q=4'b0101, LengthErr=0.
- Same capture, macro off -> TDO sequence 1,0,0,0.
- Capture, 3 shifts, Update -> LengthErr=1 and Q updated; 6 shifts -> LengthErr=1; next Capture -> LengthErr=0.
- Shift and Update asserted on the same edge -> Q equals the pre-edge shift value; shift register advances by one bit.
- Reset asserted after 2 shifts -> Q=RESET_INSTR, shift=0, cnt=0; subsequent Update without capture -> Q=0, LengthErr=1.

Source files
------------

// File: rtl/instruction_register_if.sv
// Bus between the TAP controller and instruction_register: scan data, enables, status and decoded outputs.
// TAP side uses the master modport; the register uses the slave modport.
interface instruction_register_if #(
  parameter int WIDTH = 4
);
  logic             TDI;
  logic             CaptureIR;
  logic             ShiftIR;
  logic             UpdateIR;
  logic [WIDTH-3:0] Status;
  logic             TDO;
  logic [WIDTH-1:0] Q;
  logic             LengthErr;

  modport master (
    output TDI, CaptureIR, ShiftIR, UpdateIR, Status,
    input  TDO, Q, LengthErr
  );

  modport slave (
    input  TDI, CaptureIR, ShiftIR, UpdateIR, Status,
    output TDO, Q, LengthErr
  );
endinterface

// File: rtl/instruction_register.sv
// WIDTH-bit JTAG instruction register: shift stage, update stage, 1149.1 capture pattern and shift-length check.
// Q/LengthErr update on the UpdateIR edge; TDO is shift[0] (flop). Optional macro IR_CAPTURE_STATUS_EN loads Status on capture.
module instruction_register #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_INSTR = {WIDTH{1'b1}}
) (
  input logic                   ClockIR,
  input logic                   Reset,
  instruction_register_if.slave ir
);

  localparam int             CW      = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_LEN = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH + 1);

  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [WIDTH-1:0] instr_q, instr_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             err_q, err_nxt;
  logic [WIDTH-1:0] cap_val;

`ifdef IR_CAPTURE_STATUS_EN
  assign cap_val = {ir.Status, 2'b01};
`else
  logic unused_status;
  assign unused_status = ^ir.Status;
  assign cap_val       = {{(WIDTH-2){1'b0}}, 2'b01};
`endif

  // Update acts on the pre-edge shift/cnt, independently of the shift-register operation.
  always_comb begin
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    instr_nxt = instr_q;
    err_nxt   = err_q;
    if (ir.CaptureIR) begin
      shift_nxt = cap_val;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (ir.ShiftIR) begin
      shift_nxt = {ir.TDI, shift_q[WIDTH-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end
    if (ir.UpdateIR) begin
      instr_nxt = shift_q;
      if (cnt_q != CNT_LEN) begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge ClockIR) begin
    if (Reset) begin
      shift_q <= '0;
      instr_q <= RESET_INSTR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      instr_q <= instr_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  assign ir.TDO       = shift_q[0];
  assign ir.Q         = instr_q;
  assign ir.LengthErr = err_q;

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register (WIDTH=4): driver queues hand-computed expectations, monitor checks after each edge.
module tb_instruction_register;

  localparam int WIDTH = 4;
`ifdef IR_CAPTURE_STATUS_EN
  localparam bit ON = 1'b1;
`else
  localparam bit ON = 1'b0;
`endif

  typedef struct {
    int tdo;
    int q;
    int le;
  } exp_t;

  logic ClockIR = 1'b0;
  logic Reset   = 1'b1;

  instruction_register_if #(.WIDTH(WIDTH)) irb ();

  instruction_register #(.WIDTH(WIDTH)) dut (
    .ClockIR (ClockIR),
    .Reset   (Reset),
    .ir      (irb.slave)
  );

  always #5 ClockIR = ~ClockIR;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string nm, input string fld, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, expv);
      end
    end
  endtask

  // Monitor: one expectation per driven cycle, compared after the edge settles.
  exp_t  cur;
  string cur_nm;
  always @(posedge ClockIR) begin
    #2;
    if (exp_q.size() > 0) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      check(cur_nm, "TDO", int'(irb.TDO), cur.tdo);
      check(cur_nm, "Q", int'(irb.Q), cur.q);
      check(cur_nm, "LengthErr", int'(irb.LengthErr), cur.le);
    end
  end

  // Drive one cycle of stimulus and queue the state expected after that edge (-1 = not checked).
  task automatic step(input string nm, input bit rst, input bit cap, input bit sh, input bit upd,
                      input bit tdi, input int e_tdo, input int e_q, input int e_le);
    exp_t e;
    @(negedge ClockIR);
    Reset         = rst;
    irb.CaptureIR = cap;
    irb.ShiftIR   = sh;
    irb.UpdateIR  = upd;
    irb.TDI       = tdi;
    e.tdo = e_tdo;
    e.q   = e_q;
    e.le  = e_le;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    int t_a[4];
    int t_b[4];
    irb.TDI       = 1'b0;
    irb.CaptureIR = 1'b0;
    irb.ShiftIR   = 1'b0;
    irb.UpdateIR  = 1'b0;
    irb.Status    = 2'b10;

    // Reset dominates enables
    step("reset", 1, 1, 0, 1, 0, 0, 15, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 15, 0);

    // Capture then exact-length scan of 1,0,1,0
    step("cap1", 0, 1, 0, 0, 0, 1, 15, 0);
    t_a = '{1, 0, 1, 0};
    t_b = '{0, 0, (ON ? 1 : 0), 1};
    for (int i = 0; i < 4; i++)
      step($sformatf("scan1_%0d", i), 0, 0, 1, 0, t_a[i][0], t_b[i], 15, 0);
    step("upd1", 0, 0, 0, 1, 0, 1, 5, 0);
    step("upd1_hold", 0, 0, 0, 1, 0, 1, 5, 0);

    // Short scan (3 shifts): Q still loads, flag set and sticky
    step("cap2", 0, 1, 0, 0, 0, 1, 5, 0);
    t_b = '{0, 0, (ON ? 1 : 0), 0};
    for (int i = 0; i < 3; i++)
      step($sformatf("short_%0d", i), 0, 0, 1, 0, 0, t_b[i], 5, 0);
    step("upd_short", 0, 0, 0, 1, 0, (ON ? 1 : 0), (ON ? 1 : 0), 1);
    step("sticky", 0, 0, 1, 0, 1, 0, (ON ? 1 : 0), 1);
    step("cap3_clr", 0, 1, 0, 0, 0, 1, (ON ? 1 : 0), 0);

    // Long scan (6 shifts of 1)
    for (int i = 0; i < 6; i++)
      step($sformatf("long_%0d", i), 0, 0, 1, 0, 1, (i >= 3) ? 1 : -1, (ON ? 1 : 0), 0);
    step("upd_long", 0, 0, 0, 1, 0, 1, 15, 1);
    step("cap4_clr", 0, 1, 0, 0, 0, 1, 15, 0);

    // Very long scan (12 shifts): counter must saturate, not wrap back to WIDTH
    for (int i = 0; i < 12; i++)
      step($sformatf("vlong_%0d", i), 0, 0, 1, 0, 0, (i >= 3) ? 0 : -1, 15, 0);
    step("upd_vlong", 0, 0, 0, 1, 0, 0, 0, 1);

    // Shift and update on the same edge
    step("cap5", 0, 1, 0, 0, 0, 1, 0, 0);
    t_a = '{1, 1, 0, 0};
    t_b = '{0, 0, (ON ? 1 : 0), 1};
    for (int i = 0; i < 4; i++)
      step($sformatf("scan5_%0d", i), 0, 0, 1, 0, t_a[i][0], t_b[i], 0, 0);
    step("shift_upd", 0, 0, 1, 1, 1, 1, 3, 0);
    step("upd_after5", 0, 0, 0, 1, 0, 1, 9, 1);

    // Reset mid-scan, then update without capture
    step("cap6", 0, 1, 0, 0, 0, 1, 9, 0);
    step("pre_rst_0", 0, 0, 1, 0, 1, 0, 9, 0);
    step("pre_rst_1", 0, 0, 1, 0, 1, 0, 9, 0);
    step("rst_mid", 1, 0, 1, 1, 1, 0, 15, 0);
    step("upd_norst", 0, 0, 0, 1, 0, 0, 0, 1);
    step("idle_end", 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge ClockIR);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
